// File: rtl/rtr_inject_sched_pkg.sv
// Shared types and width helpers for the injection scheduler.
// Optional feature macro: RTR_INJECT_SCHED_CREDIT_BYPASS_EN (same-cycle credit bypass).
package rtr_inject_sched_pkg;

    typedef enum logic {
        LockIdle,
        LockLocked
    } lock_state_e;

    // Index width for n items; never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Owner index width, sized from the number of requesters.
    function automatic int unsigned owner_idx_width(input int unsigned num_requesters);
        return idx_width(num_requesters);
    endfunction

    // Counter must hold 0..depth inclusive.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rtr_inject_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner only on a grant.
module rtr_inject_sched_rr_arb
    import rtr_inject_sched_pkg::*;
#(
    parameter int unsigned num_req = 4,
    localparam int unsigned IdxW = idx_width(num_req)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [num_req-1:0] req_i,
    output logic [num_req-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [IdxW-1:0]    gnt_idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned cand;
        cand        = 0;
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            cand = (32'(ptr_q) + i) % num_req;
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IdxW'(cand);
            end
        end
        if (gnt_valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid_o) begin
            ptr_d = (gnt_idx_o == IdxW'(num_req - 1)) ? '0 : gnt_idx_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rtr_inject_sched.sv
// Injection scheduler: shares one router injection port across sources with per-VC
// wormhole locks and credits. Macro RTR_INJECT_SCHED_CREDIT_BYPASS_EN enables credit bypass.
module rtr_inject_sched
    import rtr_inject_sched_pkg::*;
#(
    parameter int unsigned num_requesters  = 4,
    parameter int unsigned num_vcs         = 2,
    parameter int unsigned buffer_size     = 8,
    parameter int unsigned flit_data_width = 64,
    localparam int unsigned vc_idx_width   = idx_width(num_vcs)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [num_requesters-1:0]                  req_valid,
    input  logic [num_requesters-1:0]                  req_head,
    input  logic [num_requesters-1:0]                  req_tail,
    input  logic [num_requesters*vc_idx_width-1:0]     req_vc,
    input  logic [num_requesters*flit_data_width-1:0]  req_data,
    output logic [num_requesters-1:0]                  req_ready,
    output logic                                       flit_valid,
    output logic                                       flit_head,
    output logic                                       flit_tail,
    output logic [vc_idx_width-1:0]                    flit_vc,
    output logic [flit_data_width-1:0]                 flit_data,
    input  logic                                       credit_valid,
    input  logic [vc_idx_width-1:0]                    credit_vc,
    output logic                                       error
);

    localparam int unsigned OwnerW  = owner_idx_width(num_requesters);
    localparam int unsigned CreditW = credit_width(buffer_size);
    localparam logic [CreditW-1:0] CreditMax = CreditW'(buffer_size);

    logic [num_vcs-1:0]              has_credit;
    logic [num_vcs-1:0]              locked;
    logic [num_vcs-1:0][OwnerW-1:0]  owner;
    logic [num_vcs-1:0]              vc_gnt;
    logic [num_vcs-1:0]              ret_full;

    logic [num_requesters-1:0] eligible;
    logic [num_requesters-1:0] proto_err;
    logic                      gnt_valid;
    logic [OwnerW-1:0]         gnt_idx;

    logic                       flit_valid_q, flit_valid_d;
    logic                       flit_head_q, flit_head_d;
    logic                       flit_tail_q, flit_tail_d;
    logic [vc_idx_width-1:0]    flit_vc_q, flit_vc_d;
    logic [flit_data_width-1:0] flit_data_q, flit_data_d;
    logic                       error_q, error_d;

    // Eligibility and protocol checks; each source targets exactly one VC.
    always_comb begin
        logic [vc_idx_width-1:0] vc;
        logic                    own;
        logic                    idle;
        vc        = '0;
        own       = 1'b0;
        idle      = 1'b0;
        eligible  = '0;
        proto_err = '0;
        for (int r = 0; r < num_requesters; r++) begin
            vc   = req_vc[r*vc_idx_width +: vc_idx_width];
            own  = locked[vc] && (owner[vc] == OwnerW'(r));
            idle = !locked[vc];
            if (req_valid[r]) begin
                if (req_head[r] == own) begin
                    proto_err[r] = 1'b1;
                end
                if (has_credit[vc] && ((idle && req_head[r]) || (own && !req_head[r]))) begin
                    eligible[r] = 1'b1;
                end
            end
        end
    end

    rtr_inject_sched_rr_arb #(
        .num_req (num_requesters)
    ) u_arb (
        .clk_i       (clk),
        .rst_ni      (reset),
        .req_i       (eligible),
        .gnt_o       (req_ready),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // Grant is one-hot, so an OR-style mux selects the winning flit.
    always_comb begin
        flit_valid_d = gnt_valid;
        flit_head_d  = 1'b0;
        flit_tail_d  = 1'b0;
        flit_vc_d    = '0;
        flit_data_d  = '0;
        for (int r = 0; r < num_requesters; r++) begin
            if (req_ready[r]) begin
                flit_head_d = req_head[r];
                flit_tail_d = req_tail[r];
                flit_vc_d   = req_vc[r*vc_idx_width +: vc_idx_width];
                flit_data_d = req_data[r*flit_data_width +: flit_data_width];
            end
        end
    end

    for (genvar v = 0; v < num_vcs; v++) begin : g_vc
        logic [CreditW-1:0] credit_q, credit_d;
        lock_state_e        lock_q, lock_d;
        logic [OwnerW-1:0]  owner_q, owner_d;
        logic               ret;

        assign ret         = credit_valid && (credit_vc == vc_idx_width'(v));
        assign ret_full[v] = ret && (credit_q == CreditMax);
        assign vc_gnt[v]   = gnt_valid && (flit_vc_d == vc_idx_width'(v));
        assign locked[v]   = (lock_q == LockLocked);
        assign owner[v]    = owner_q;
`ifdef RTR_INJECT_SCHED_CREDIT_BYPASS_EN
        assign has_credit[v] = (credit_q != '0) || ret;
`else
        assign has_credit[v] = (credit_q != '0);
`endif

        always_comb begin
            credit_d = credit_q;
            if (vc_gnt[v] && !ret) begin
                credit_d = credit_q - CreditW'(1);
            end else if (ret && !vc_gnt[v] && !ret_full[v]) begin
                credit_d = credit_q + CreditW'(1);
            end
        end

        // Head+tail packets pass through without taking the lock.
        always_comb begin
            lock_d  = lock_q;
            owner_d = owner_q;
            if (vc_gnt[v]) begin
                if (lock_q == LockIdle && flit_head_d && !flit_tail_d) begin
                    lock_d  = LockLocked;
                    owner_d = gnt_idx;
                end else if (lock_q == LockLocked && flit_tail_d) begin
                    lock_d = LockIdle;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                credit_q <= CreditMax;
                lock_q   <= LockIdle;
                owner_q  <= '0;
            end else begin
                credit_q <= credit_d;
                lock_q   <= lock_d;
                owner_q  <= owner_d;
            end
        end
    end

    assign error_d = error_q || (|proto_err) || (|ret_full);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_valid_q <= 1'b0;
            flit_head_q  <= 1'b0;
            flit_tail_q  <= 1'b0;
            flit_vc_q    <= '0;
            flit_data_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            flit_valid_q <= flit_valid_d;
            flit_head_q  <= flit_head_d;
            flit_tail_q  <= flit_tail_d;
            flit_vc_q    <= flit_vc_d;
            flit_data_q  <= flit_data_d;
            error_q      <= error_d;
        end
    end

    assign flit_valid = flit_valid_q;
    assign flit_head  = flit_head_q;
    assign flit_tail  = flit_tail_q;
    assign flit_vc    = flit_vc_q;
    assign flit_data  = flit_data_q;
    assign error      = error_q;

endmodule

// File: tb/tb_rtr_inject_sched.sv
// Directed bench for rtr_inject_sched; expectations follow RTR_INJECT_SCHED_CREDIT_BYPASS_EN.
module tb_rtr_inject_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned NV = 2;
    localparam int unsigned BS = 8;
    localparam int unsigned DW = 64;
    localparam int unsigned VW = 1;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid, req_head, req_tail, req_ready;
    logic [NR*VW-1:0]  req_vc;
    logic [NR*DW-1:0]  req_data;
    logic              flit_valid, flit_head, flit_tail;
    logic [VW-1:0]     flit_vc;
    logic [DW-1:0]     flit_data;
    logic              credit_valid;
    logic [VW-1:0]     credit_vc;
    logic              error;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    rtr_inject_sched #(
        .num_requesters  (NR),
        .num_vcs         (NV),
        .buffer_size     (BS),
        .flit_data_width (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_head     (req_head),
        .req_tail     (req_tail),
        .req_vc       (req_vc),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .flit_valid   (flit_valid),
        .flit_head    (flit_head),
        .flit_tail    (flit_tail),
        .flit_vc      (flit_vc),
        .flit_data    (flit_data),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ready(input string tag, input logic [NR-1:0] exp);
        #1;
        chk(tag, 64'(req_ready), 64'(exp));
    endtask

    task automatic chk_flit(input string tag, input logic h, input logic t, input logic [VW-1:0] vc,
                            input logic [DW-1:0] d);
        chk({tag, "_valid"}, 64'(flit_valid), 64'(1'b1));
        chk({tag, "_head"}, 64'(flit_head), 64'(h));
        chk({tag, "_tail"}, 64'(flit_tail), 64'(t));
        chk({tag, "_vc"}, 64'(flit_vc), 64'(vc));
        chk({tag, "_data"}, flit_data, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_head  = '0;
        req_tail  = '0;
        req_vc    = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int r, input logic h, input logic t, input logic [VW-1:0] vc,
                           input logic [DW-1:0] d);
        req_valid[r]          = 1'b1;
        req_head[r]           = h;
        req_tail[r]           = t;
        req_vc[r*VW +: VW]    = vc;
        req_data[r*DW +: DW]  = d;
    endtask

    task automatic do_reset(input string tag);
        reset        = 1'b0;
        credit_valid = 1'b0;
        credit_vc    = '0;
        clear_reqs();
        #2;
        chk({tag, "_rst_valid"}, 64'(flit_valid), 64'(1'b0));
        chk({tag, "_rst_data"}, flit_data, 64'(0));
        chk({tag, "_rst_error"}, 64'(error), 64'(1'b0));
        chk({tag, "_rst_ready"}, 64'(req_ready), 64'(0));
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int unsigned idx [2];
        int          w;

        do_reset("init");

        // 3-flit packet from source 0 on VC0.
        set_req(0, 1'b1, 1'b0, 1'b0, 64'hA0);
        chk_ready("t1_head_rdy", 4'b0001);
        tick();
        chk_flit("t1_head", 1'b1, 1'b0, 1'b0, 64'hA0);
        set_req(0, 1'b0, 1'b0, 1'b0, 64'hA1);
        chk_ready("t1_body_rdy", 4'b0001);
        tick();
        chk_flit("t1_body", 1'b0, 1'b0, 1'b0, 64'hA1);
        set_req(0, 1'b0, 1'b1, 1'b0, 64'hA2);
        chk_ready("t1_tail_rdy", 4'b0001);
        tick();
        chk_flit("t1_tail", 1'b0, 1'b1, 1'b0, 64'hA2);
        clear_reqs();
        tick();
        chk("t1_idle_valid", 64'(flit_valid), 64'(1'b0));

        // Sources 1 and 2 contend for VC0; source 2 waits for source 1's tail.
        set_req(1, 1'b1, 1'b0, 1'b0, 64'hB0);
        set_req(2, 1'b1, 1'b1, 1'b0, 64'hC0);
        chk_ready("t2_contend_rdy", 4'b0010);
        tick();
        chk_flit("t2_s1_head", 1'b1, 1'b0, 1'b0, 64'hB0);
        set_req(1, 1'b0, 1'b1, 1'b0, 64'hB1);
        chk_ready("t2_s1_tail_rdy", 4'b0010);
        tick();
        chk_flit("t2_s1_tail", 1'b0, 1'b1, 1'b0, 64'hB1);
        req_valid[1] = 1'b0;
        chk_ready("t2_s2_rdy", 4'b0100);
        tick();
        chk_flit("t2_s2", 1'b1, 1'b1, 1'b0, 64'hC0);
        chk("t2_no_error", 64'(error), 64'(1'b0));

        // Mid-packet reset must clear the lock held by source 1.
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 1'b0, 64'hB2);
        chk_ready("t2_relock_rdy", 4'b0010);
        tick();
        do_reset("t2_mid");
        set_req(2, 1'b1, 1'b1, 1'b0, 64'hC1);
        chk_ready("t2_after_rst_rdy", 4'b0100);
        tick();
        chk_flit("t2_after_rst", 1'b1, 1'b1, 1'b0, 64'hC1);

        // Two 4-flit packets on different VCs interleave 0,1,0,1...
        do_reset("t3");
        idx[0] = 0;
        idx[1] = 0;
        for (int g = 0; g < 8; g++) begin
            clear_reqs();
            for (int s = 0; s < 2; s++) begin
                if (idx[s] < 4) begin
                    set_req(s, idx[s] == 0, idx[s] == 3, VW'(s), 64'(s * 16 + idx[s]));
                end
            end
            w = g % 2;
            chk_ready("t3_rdy", 4'(1 << w));
            tick();
            chk_flit("t3_flit", idx[w] == 0, idx[w] == 3, VW'(w), 64'(w * 16 + idx[w]));
            idx[w]++;
        end
        clear_reqs();

        // Credit exhaustion on VC0 and release by a returned credit.
        do_reset("t4");
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b1, 1'b1, 1'b0, 64'(i));
            chk_ready("t4_fill_rdy", 4'b0001);
            tick();
        end
        set_req(0, 1'b1, 1'b1, 1'b0, 64'hD9);
        chk_ready("t4_stall_rdy", 4'b0000);
        tick();
        chk("t4_stall_valid", 64'(flit_valid), 64'(1'b0));
        credit_valid = 1'b1;
        credit_vc    = 1'b0;
`ifdef RTR_INJECT_SCHED_CREDIT_BYPASS_EN
        chk_ready("t4_ret_same_rdy", 4'b0001);
        tick();
        credit_valid = 1'b0;
        chk_flit("t4_ret_flit", 1'b1, 1'b1, 1'b0, 64'hD9);
        chk_ready("t4_after_rdy", 4'b0000);
        tick();
`else
        chk_ready("t4_ret_same_rdy", 4'b0000);
        tick();
        credit_valid = 1'b0;
        chk("t4_ret_gap_valid", 64'(flit_valid), 64'(1'b0));
        chk_ready("t4_ret_next_rdy", 4'b0001);
        tick();
        chk_flit("t4_ret_flit", 1'b1, 1'b1, 1'b0, 64'hD9);
`endif
        chk("t4_no_error", 64'(error), 64'(1'b0));
        clear_reqs();

        // Body flit on an idle VC is a protocol error, sticky until reset.
        do_reset("t5");
        set_req(3, 1'b0, 1'b0, 1'b1, 64'hE0);
        chk_ready("t5_body_rdy", 4'b0000);
        tick();
        chk("t5_error_set", 64'(error), 64'(1'b1));
        chk("t5_no_flit", 64'(flit_valid), 64'(1'b0));
        clear_reqs();
        tick();
        tick();
        chk("t5_error_sticky", 64'(error), 64'(1'b1));

        // Credit return at full credits: error, and the counter stays saturated.
        do_reset("t6");
        credit_valid = 1'b1;
        credit_vc    = 1'b1;
        tick();
        credit_valid = 1'b0;
        chk("t6_error_set", 64'(error), 64'(1'b1));
        for (int i = 0; i < 8; i++) begin
            set_req(2, 1'b1, 1'b1, 1'b1, 64'(i));
            chk_ready("t6_fill_rdy", 4'b0100);
            tick();
        end
        set_req(2, 1'b1, 1'b1, 1'b1, 64'hF9);
        chk_ready("t6_stall_rdy", 4'b0000);
        tick();
        clear_reqs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rtr_inject_sched.md
# rtr_inject_sched

Injection scheduler in front of one router injection port. It shares that port between `num_requesters` node-side sources and interleaves packets across VCs. It keeps wormhole ownership per VC, so flits of different packets never mix on one VC. It tracks downstream credits per VC and drives one registered flit per cycle into the router's `channel_in_ip` slice for the local port.

## Interface
- `num_requesters`, 4: number of local sources sharing the port
- `num_vcs`, 2: VCs on the injection channel
- `buffer_size`, 8: downstream flit buffer depth per VC, which is the initial credit count
- `flit_data_width`, 64: payload width
- `vc_idx_width`, clogb(`num_vcs`): derived, never overridden
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  `num_requesters`  source r has a flit offered
- `req_head`  in  `num_requesters`  offered flit is a head
- `req_tail`  in  `num_requesters`  offered flit is a tail
- `req_vc`  in  `num_requesters*vc_idx_width`  target VC per source
- `req_data`  in  `num_requesters*flit_data_width`  payload per source
- `req_ready`  out  `num_requesters`  one-hot grant; the flit is consumed this cycle
- `flit_valid`  out  1  registered flit valid to router
- `flit_head`, `flit_tail`  out  1 each  registered flit type
- `flit_vc`  out  `vc_idx_width`  registered VC
- `flit_data`  out  `flit_data_width`  registered payload
- `credit_valid`  in  1  router returns one credit
- `credit_vc`  in  `vc_idx_width`  VC of the returned credit
- `error`  out  1  sticky protocol or credit error

## Operation
- Per-VC credit counter, width clogb(`buffer_size`+1). Reset value is `buffer_size`. It decrements on a grant to that VC and increments on `credit_valid` for that VC. A grant and a return in the same cycle on the same VC leave the counter unchanged.
- Per-VC lock FSM with states IDLE and LOCKED(owner):
  - IDLE to LOCKED(r): a head without tail from r is granted on v.
  - LOCKED(r) to IDLE: a tail from r is granted on v.
  - A head+tail flit is a single-flit packet and never locks.
- Eligibility of source r with VC v: `req_valid[r]`, credit[v] > 0, and one of the following:
  - v is IDLE and `req_head[r]`
  - v is LOCKED(r) and not `req_head[r]`
- Arbitration: round-robin over eligible sources with at most one grant per cycle. The pointer moves to the source after the winner, and only on a grant.
- Protocol violations set `error` sticky and leave the offending flit ungranted:
  - non-head from r on a VC not LOCKED(r)
  - head from r on a VC that is LOCKED(r)
  - `credit_valid` on a VC whose counter already equals `buffer_size`; the counter saturates.
- A head on a VC locked by another source is not an error. That source waits.
- Reset values: `req_ready` 0, `flit_valid` 0, all other flit outputs 0, `error` 0, credits at `buffer_size`, all locks IDLE, pointer 0.

## Timing
- `req_ready` is combinational from the request inputs, credit counters and lock state. The source drops or advances its flit the same cycle.
- Latency: a flit granted in cycle t appears on the `flit_*` outputs in cycle t+1. `flit_valid` is high for exactly one cycle per grant.
- The credit counter and lock updates from a grant in cycle t are visible in cycle t+1. A back-to-back flit from the same owner in cycle t+1 is eligible.
- When credit[v] is 0, no grant is made to v until a credit has arrived, as set by the Configuration section.
- If `reset` is asserted mid-packet, all locks clear and credits are restored asynchronously. The bench reinitialises the downstream buffers.

## Configuration
- `RTR_INJECT_SCHED_CREDIT_BYPASS_EN` defined: a credit returned in cycle t counts toward eligibility in cycle t. This adds a combinational path from `credit_vc` to `req_ready`, and a VC at 0 credits can be granted in the same cycle its credit arrives.
- Undefined: returned credits count from t+1 only, and there is no combinational input-to-grant path from the credit interface.

## Structure
- Shared package `rtr_inject_sched_pkg` holds:
  - the lock-state enum (IDLE, LOCKED)
  - the owner index width clogb(`num_requesters`)
  - the credit counter width function
- One sub-module, `rtr_inject_sched_rr_arb`: a parameterised round-robin arbiter with request vector in, one-hot grant out, and a pointer register updated on grant.
- Credit counters and lock FSMs are generate loops over `num_vcs` in the top.

## Test plan
- After reset, source 0 sends a 3-flit packet on VC0 -> `flit_valid` in cycles 1..3 with head/body/tail, and credit[VC0] = 5.
- Sources 1 and 2 send heads on VC0 together -> source 1 wins. Source 2 waits until source 1's tail is granted, then gets VC0 the next cycle.
- Source 0 on VC0 and source 1 on VC1 with 4-flit packets each -> grants alternate 0,1,0,1…, and output VCs interleave with each VC's flits contiguous.
- With no credits returned, 8 flits on VC0 -> the 9th flit is stalled. `credit_valid` on VC0 at cycle t -> grant at t+1 with the macro undefined, at t with it defined.
- Body flit from source 3 on IDLE VC1 -> no grant and `error` = 1. It stays 1 until reset.
- Credit return on VC1 at full credits (8) -> `error` = 1 and credit[VC1] stays 8.
